// File: rtl/multi_adc_axis_packer.sv
// rtl/multi_adc_axis_packer.sv - buffers NC-channel ADC sample sets and serialises them onto an AXI4-Stream master
// Optional feature macro: ADC_TEST_PATTERN_EN (adds TEST_MODE counting-pattern source)
module multi_adc_axis_packer #(
  parameter int NUM_CHANNELS         = 4,
  parameter int SAMPLE_WIDTH         = 16,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int PACKET_SETS          = 256
) (
  input  logic                                   M_AXIS_ACLK,
  input  logic                                   M_AXIS_ARESETN,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]   CH_DATA_IN,
  input  logic                                   DATA_IN_VALID,
  input  logic                                   CAPTURE_EN,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                                   TEST_MODE,
`endif
  output logic                                   M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]        M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]      M_AXIS_TSTRB,
  output logic                                   M_AXIS_TLAST,
  input  logic                                   M_AXIS_TREADY,
  output logic                                   OVERFLOW,
  output logic [15:0]                            OVERFLOW_COUNT
);
  localparam int SET_W = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int TDW   = C_M_AXIS_TDATA_WIDTH;
  localparam int WPS   = SET_W / TDW;
  localparam int WW    = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SCW   = (PACKET_SETS > 1) ? $clog2(PACKET_SETS) : 1;
  localparam logic [WW-1:0]  W_LAST   = WW'(WPS - 1);
  localparam logic [SCW-1:0] S_LAST   = SCW'(PACKET_SETS - 1);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [SET_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_nxt;
  logic [AW:0]       count_q;
  logic [WW-1:0]     w_q, w_d;
  logic [SCW-1:0]    set_q, set_d;
  logic [TDW-1:0]    tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              ovf_q;
  logic [15:0]       ovf_cnt_q;
  logic [SET_W-1:0]  push_data, sel_set;
  logic              push_req, push_ok, drop, pop, full_eff, load;

`ifdef ADC_TEST_PATTERN_EN
  logic [SAMPLE_WIDTH-1:0] pat_cnt;
  logic [SET_W-1:0]        pattern;

  always_comb begin
    pattern = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      pattern[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = pat_cnt + SAMPLE_WIDTH'(k);
    push_data = TEST_MODE ? pattern : CH_DATA_IN;
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN)
      pat_cnt <= '0;
    else if (push_ok && TEST_MODE)
      pat_cnt <= pat_cnt + 1'b1;
  end
`else
  assign push_data = CH_DATA_IN;
`endif

  // Full is judged after a same-edge pop so a refill on the head's final word is not lost.
  assign rd_nxt   = rd_ptr + AW'(1);
  assign pop      = (state_q == SEND) && M_AXIS_TREADY && (w_q == W_LAST);
  assign push_req = DATA_IN_VALID && CAPTURE_EN;
  assign full_eff = (count_q == FULL_CNT) && !pop;
  assign push_ok  = push_req && !full_eff;
  assign drop     = push_req && full_eff;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    set_d   = set_q;
    sel_set = mem[rd_ptr];
    load    = 1'b0;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          w_d     = '0;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (M_AXIS_TREADY) begin
          if (w_q != W_LAST) begin
            w_d  = w_q + 1'b1;
            load = 1'b1;
          end else begin
            w_d   = '0;
            set_d = (set_q == S_LAST) ? '0 : set_q + 1'b1;
            if (count_q > (AW+1)'(1)) begin
              sel_set = mem[rd_nxt];
              load    = 1'b1;
            end else if (push_ok) begin
              // The only remaining set is the one being written this edge.
              sel_set = push_data;
              load    = 1'b1;
            end else begin
              state_d = IDLE;
              tlast_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tdata_d = sel_set[w_d*TDW +: TDW];
      tlast_d = (w_d == W_LAST) && (set_d == S_LAST);
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_q   <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      w_q       <= '0;
      set_q     <= '0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      set_q   <= set_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_nxt;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != 16'hFFFF)
          ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
    end
  end

  assign M_AXIS_TVALID  = (state_q == SEND);
  assign M_AXIS_TDATA   = tdata_q;
  assign M_AXIS_TLAST   = tlast_q;
  assign M_AXIS_TSTRB   = '1;
  assign OVERFLOW       = ovf_q;
  assign OVERFLOW_COUNT = ovf_cnt_q;
endmodule

// File: tb/tb_multi_adc_axis_packer.sv
// tb/tb_multi_adc_axis_packer.sv - directed self-checking bench for multi_adc_axis_packer (PACKET_SETS=4)
module tb_multi_adc_axis_packer;
    logic        clk = 1'b0;
    logic        resetn, din_valid, capture_en, tready;
    logic [63:0] ch_data;
`ifdef ADC_TEST_PATTERN_EN
    logic        test_mode;
`endif
    logic        tvalid, tlast, ovf;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [15:0] ovf_cnt;
    int          n_cmp = 0, n_err = 0, cyc = 0;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];

    always #5 clk = ~clk;

    multi_adc_axis_packer #(.PACKET_SETS(4)) dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(resetn), .CH_DATA_IN(ch_data),
        .DATA_IN_VALID(din_valid), .CAPTURE_EN(capture_en),
`ifdef ADC_TEST_PATTERN_EN
        .TEST_MODE(test_mode),
`endif
        .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
        .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready),
        .OVERFLOW(ovf), .OVERFLOW_COUNT(ovf_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_set(input int i);
        return {16'(256*i + 3), 16'(256*i + 2), 16'(256*i + 1), 16'(256*i)};
    endfunction

    function automatic logic [31:0] exp_word(input int i, input int w);
        return (w == 0) ? {16'(256*i + 1), 16'(256*i)} : {16'(256*i + 3), 16'(256*i + 2)};
    endfunction

    task automatic step();
        logic        hold;
        logic [31:0] hd;
        logic        hl;
        hold = tvalid && !tready && resetn;
        hd   = tdata;
        hl   = tlast;
        if (tvalid && tready && resetn) begin
            got_d.push_back(tdata);
            got_l.push_back(tlast);
            got_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hold) begin
            check("hold_tvalid", tvalid, 1'b1);
            check("hold_tdata", tdata, hd);
            check("hold_tlast", tlast, hl);
        end
    endtask

    task automatic clear_q();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        din_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
        clear_q();
    endtask

    task automatic push(input logic [63:0] d);
        ch_data   = d;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && got_d.size() < n; i++) step();
        check(tag, got_d.size(), n);
    endtask

    task automatic check_stream(input int first, input int nsets);
        for (int j = 0; j < got_d.size() && j < 2*nsets; j++) begin
            check("word_data", got_d[j], exp_word(first + j/2, j%2));
            check("word_last", got_l[j], 1'((j % 8) == 7));
        end
    endtask

    initial begin
        resetn = 1'b0; din_valid = 1'b0; capture_en = 1'b1; tready = 1'b0; ch_data = '0;
`ifdef ADC_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        do_reset();
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_ovf_cnt", ovf_cnt, 16'h0);
        check("tstrb", tstrb, 4'hF);

        tready = 1'b1;
        push({16'h000D, 16'h000C, 16'h000B, 16'h000A});
        check("t1_push_edge_tvalid", tvalid, 1'b0);
        step();
        check("t1_w0_tvalid", tvalid, 1'b1);
        check("t1_w0_tdata", tdata, 32'h000B000A);
        check("t1_w0_tlast", tlast, 1'b0);
        step();
        check("t1_w1_tvalid", tvalid, 1'b1);
        check("t1_w1_tdata", tdata, 32'h000D000C);
        check("t1_w1_tlast", tlast, 1'b0);
        step();
        check("t1_idle", tvalid, 1'b0);

        clear_q();
        capture_en = 1'b0;
        push(mk_set(9));
        for (int i = 0; i < 4; i++) step();
        check("capoff_words", got_d.size(), 0);
        check("capoff_tvalid", tvalid, 1'b0);
        capture_en = 1'b1;

        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) push(mk_set(i));
        collect(16, 40, "t2_count");
        check_stream(0, 8);
        if (got_c.size() == 16) check("t2_contiguous", got_c[15] - got_c[0], 15);

        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 19; i++) push(mk_set(i));
        check("t3_ovf", ovf, 1'b1);
        check("t3_ovf_cnt", ovf_cnt, 16'd3);
        tready = 1'b1;
        collect(32, 80, "t3_count");
        check_stream(0, 16);
        for (int i = 0; i < 4; i++) step();
        check("t3_no_extra", got_d.size(), 32);

        clear_q();
        push(mk_set(100));
        push(mk_set(101));
        collect(3, 20, "t5_pre_words");
        check("t5_pre_ovf_cnt", ovf_cnt, 16'd3);
        resetn = 1'b0;
        step();
        check("t5_rst_tvalid", tvalid, 1'b0);
        check("t5_rst_ovf_cnt", ovf_cnt, 16'd0);
        check("t5_rst_ovf", ovf, 1'b0);
        resetn = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) push(mk_set(200 + i));
        collect(8, 40, "t5_count");
        check_stream(200, 4);

        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 16; i++) push(mk_set(i));
        tready = 1'b1;
        step();
        push(mk_set(16));
        check("full_pop_ovf", ovf, 1'b0);
        check("full_pop_ovf_cnt", ovf_cnt, 16'd0);
        collect(34, 80, "full_pop_count");
        check_stream(0, 17);

        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(mk_set(50 + i));
            tready = ~tready;
        end
        for (int i = 0; i < 60 && got_d.size() < 8; i++) begin
            step();
            tready = ~tready;
        end
        check("t4_count", got_d.size(), 8);
        check_stream(50, 4);

`ifdef ADC_TEST_PATTERN_EN
        do_reset();
        tready    = 1'b1;
        test_mode = 1'b1;
        push(64'h0);
        push(64'h0);
        test_mode = 1'b0;
        collect(4, 20, "t6_count");
        if (got_d.size() == 4) begin
            check("t6_w0", got_d[0], 32'h00010000);
            check("t6_w1", got_d[1], 32'h00030002);
            check("t6_w2", got_d[2], 32'h00020001);
            check("t6_w3", got_d[3], 32'h00040003);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
